// File: rtl/memory_bus_if.sv
// memory_bus_if
// Valid/ready request and response channels between the fetch-side initiator
// (master) and the memory responder (slave).
//   req_valid/req_ready      request handshake
//   req_is_write, req_addr,  request payload (byte address, 64-bit data,
//   req_wdata, req_core_id   8-bit requester tag)
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_is_write, resp_core_id, resp_error   response payload
interface memory_bus_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [63:0]           req_wdata;
  logic [7:0]            req_core_id;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [63:0]           resp_data;
  logic                  resp_is_write;
  logic [7:0]            resp_core_id;
  logic                  resp_error;

  modport master (
    output req_valid, req_is_write, req_addr, req_wdata, req_core_id, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_is_write, resp_core_id, resp_error
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_wdata, req_core_id, resp_ready,
    output req_ready, resp_valid, resp_data, resp_is_write, resp_core_id, resp_error
  );
endinterface

// File: rtl/memory_bus_responder.sv
// memory_bus_responder
// Responder end of the fetch memory bus. Requests are queued in an in-order
// FIFO, serviced one at a time against a word-addressed 64-bit RAM after
// LATENCY cycles, and answered with one registered response each.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous reset, active low (RAM contents are kept)
//   bus      memory_bus_if slave modport (request and response channels)
module memory_bus_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORDS_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  memory_bus_if.slave    bus
);

  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int ENT_W       = 1 + 8 + 64 + ADDR_WIDTH;
  localparam int DEPTH_WORDS = 1 << WORDS_LOG2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  // Request FIFO; entry layout is {is_write, core_id, wdata, addr}
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             fifo_empty_s, fifo_full_s;
  logic             push_s, pop_s;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ENT_W-1:0] cur_q, cur_d;

  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic             resp_is_write_q, resp_is_write_d;
  logic [7:0]       resp_core_id_q, resp_core_id_d;
  logic             resp_error_q, resp_error_d;

  logic [63:0]      ram [DEPTH_WORDS];

  logic                  cur_is_write_s;
  logic [7:0]            cur_core_id_s;
  logic [63:0]           cur_wdata_s;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [WORDS_LOG2-1:0] word_idx_s;
  logic                  addr_err_s;
  logic                  access_s;

  // Full/empty use the extra pointer bit to tell a wrapped writer from an equal one
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // No bypass: a full FIFO refuses even when it pops on the same edge
  assign bus.req_ready = reset_n & ~fifo_full_s;
  assign push_s        = bus.req_valid & bus.req_ready;

  assign cur_is_write_s = cur_q[ENT_W-1];
  assign cur_core_id_s  = cur_q[ENT_W-2 -: 8];
  assign cur_wdata_s    = cur_q[ADDR_WIDTH +: 64];
  assign cur_addr_s     = cur_q[ADDR_WIDTH-1:0];
  assign word_idx_s     = cur_addr_s[WORDS_LOG2+2:3];
  assign addr_err_s     = (cur_addr_s[2:0] != 3'd0) ||
                          ((cur_addr_s >> (WORDS_LOG2 + 3)) != {ADDR_WIDTH{1'b0}});
  assign access_s       = (state_q == ST_BUSY) && (cnt_q == 4'd0);

  assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
  assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};

  // Service FSM: pop head, count down latency, present response until taken
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cur_d           = cur_q;
    pop_s           = 1'b0;
    resp_valid_d    = resp_valid_q;
    resp_data_d     = resp_data_q;
    resp_is_write_d = resp_is_write_q;
    resp_core_id_d  = resp_core_id_q;
    resp_error_d    = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cur_d   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d         = ST_RESP;
          resp_valid_d    = 1'b1;
          resp_is_write_d = cur_is_write_s;
          resp_core_id_d  = cur_core_id_s;
          resp_error_d    = addr_err_s;
          // Read data is the RAM word before this edge's write, which cannot
          // collide anyway since only one access happens per request
          if (addr_err_s || cur_is_write_s) begin
            resp_data_d = 64'd0;
          end else begin
            resp_data_d = ram[word_idx_s];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            cur_d   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
            cnt_d   = CNT_LOAD;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      cur_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 64'd0;
      resp_is_write_q <= 1'b0;
      resp_core_id_q  <= 8'd0;
      resp_error_q    <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cur_q           <= cur_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_is_write_q <= resp_is_write_d;
      resp_core_id_q  <= resp_core_id_d;
      resp_error_q    <= resp_error_d;
    end
  end

  // Storage arrays: FIFO payload and backing RAM, never reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {bus.req_is_write, bus.req_core_id,
                                        bus.req_wdata, bus.req_addr};
    end
    if (access_s && cur_is_write_s && !addr_err_s) begin
      ram[word_idx_s] <= cur_wdata_s;
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_is_write = resp_is_write_q;
  assign bus.resp_core_id  = resp_core_id_q;
  assign bus.resp_error    = resp_error_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
module tb_memory_bus_responder;
  localparam int LAT = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  memory_bus_if #(.ADDR_WIDTH(32)) bus();
  memory_bus_if #(.ADDR_WIDTH(32)) bus_l1();
  memory_bus_if #(.ADDR_WIDTH(32)) bus_l15();

  memory_bus_responder #(.ADDR_WIDTH(32), .WORDS_LOG2(10), .LATENCY(LAT), .FIFO_DEPTH(2))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  memory_bus_responder #(.ADDR_WIDTH(32), .WORDS_LOG2(10), .LATENCY(1), .FIFO_DEPTH(2))
    dut_l1 (.clk(clk), .reset_n(reset_n), .bus(bus_l1));
  memory_bus_responder #(.ADDR_WIDTH(32), .WORDS_LOG2(10), .LATENCY(15), .FIFO_DEPTH(2))
    dut_l15 (.clk(clk), .reset_n(reset_n), .bus(bus_l15));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Tick while letting a still-presented request be accepted and withdrawn
  task automatic tick_req;
    logic acc;
    acc = bus.req_valid && bus.req_ready;
    tick();
    if (acc) bus.req_valid = 1'b0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] id);
    int n;
    bus.req_is_write = w;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_core_id  = id;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_eq("send_timeout", 64'd0, 64'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!bus.resp_valid && cyc < 100) begin
      tick_req();
      cyc++;
    end
    if (cyc >= 100) check_eq("resp_timeout", 64'd0, 64'd1);
  endtask

  // Single transaction from an idle responder, with full response check
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [63:0] d, input logic [7:0] id,
                     input logic [63:0] exp_data, input logic exp_err);
    int cyc;
    bus.resp_ready = 1'b0;
    send(w, a, d, id);
    wait_resp(cyc);
    check_eq({tag, "_lat"}, 64'(cyc), 64'(LAT + 1));
    check_eq({tag, "_data"}, bus.resp_data, exp_data);
    check_eq({tag, "_err"}, 64'(bus.resp_error), 64'(exp_err));
    check_eq({tag, "_isw"}, 64'(bus.resp_is_write), 64'(w));
    check_eq({tag, "_id"}, 64'(bus.resp_core_id), 64'(id));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  logic        bp_w  [4];
  logic [31:0] bp_a  [4];
  logic [63:0] bp_d  [4];
  logic [7:0]  bp_id [4];
  logic [63:0] bp_ex [4];

  initial begin
    int c, n, c1, c15;
    int r_c [2];
    logic [63:0] r_d [2];
    logic r_w [2];
    logic [7:0] r_id [2];

    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_is_write = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 64'd0; bus.req_core_id = 8'd0; bus.resp_ready = 1'b0;
    bus_l1.req_valid = 1'b0; bus_l1.req_is_write = 1'b0; bus_l1.req_addr = 32'd0;
    bus_l1.req_wdata = 64'd0; bus_l1.req_core_id = 8'd0; bus_l1.resp_ready = 1'b1;
    bus_l15.req_valid = 1'b0; bus_l15.req_is_write = 1'b0; bus_l15.req_addr = 32'd0;
    bus_l15.req_wdata = 64'd0; bus_l15.req_core_id = 8'd0; bus_l15.resp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst_data", bus.resp_data, 64'd0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_ready", 64'(bus.req_ready), 64'd1);
    tick();

    // Basic write then read
    txn("wr40", 1'b1, 32'h40, 64'hDEAD_BEEF_0000_0001, 8'd3, 64'd0, 1'b0);
    txn("rd40", 1'b0, 32'h40, 64'd0, 8'd4, 64'hDEAD_BEEF_0000_0001, 1'b0);

    // Write and read on consecutive cycles with resp_ready held high
    bus.resp_ready = 1'b1;
    bus.req_is_write = 1'b1; bus.req_addr = 32'h80;
    bus.req_wdata = 64'h1122_3344_5566_7788; bus.req_core_id = 8'd5; bus.req_valid = 1'b1;
    tick();
    bus.req_is_write = 1'b0; bus.req_core_id = 8'd6;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    for (int k = 1; k < 40; k++) begin
      if (bus.resp_valid && n < 2) begin
        r_c[n] = k; r_d[n] = bus.resp_data; r_w[n] = bus.resp_is_write; r_id[n] = bus.resp_core_id;
        n++;
      end
      tick();
    end
    bus.resp_ready = 1'b0;
    check_eq("b2b_count", 64'(n), 64'd2);
    if (n == 2) begin
      check_eq("b2b_first_lat", 64'(r_c[0]), 64'(LAT + 1));
      check_eq("b2b_spacing", 64'(r_c[1] - r_c[0]), 64'(LAT + 1));
      check_eq("b2b_w_isw", 64'(r_w[0]), 64'd1);
      check_eq("b2b_w_id", 64'(r_id[0]), 64'd5);
      check_eq("b2b_r_isw", 64'(r_w[1]), 64'd0);
      check_eq("b2b_r_data", r_d[1], 64'h1122_3344_5566_7788);
      check_eq("b2b_r_id", 64'(r_id[1]), 64'd6);
    end

    // Address errors leave RAM untouched
    txn("mis44", 1'b0, 32'h44, 64'd0, 8'd7, 64'd0, 1'b1);
    txn("oor", 1'b0, 32'h2000, 64'd0, 8'd8, 64'd0, 1'b1);
    txn("miswr", 1'b1, 32'h81, 64'hFFFF_FFFF_FFFF_FFFF, 8'd9, 64'd0, 1'b1);
    txn("oorwr", 1'b1, 32'h2080, 64'hAAAA_AAAA_AAAA_AAAA, 8'd9, 64'd0, 1'b1);
    txn("rd80", 1'b0, 32'h80, 64'd0, 8'd9, 64'h1122_3344_5566_7788, 1'b0);

    // Backpressure: four requests with resp_ready low
    bp_w  = '{1'b1, 1'b0, 1'b1, 1'b0};
    bp_a  = '{32'h200, 32'h200, 32'h208, 32'h208};
    bp_d  = '{64'hA5A5_0000_1111_2222, 64'd0, 64'h0BAD_CAFE_3333_4444, 64'd0};
    bp_id = '{8'd10, 8'd11, 8'd12, 8'd13};
    bp_ex = '{64'd0, 64'hA5A5_0000_1111_2222, 64'd0, 64'h0BAD_CAFE_3333_4444};
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_is_write = bp_w[i]; bus.req_addr = bp_a[i];
      bus.req_wdata = bp_d[i]; bus.req_core_id = bp_id[i]; bus.req_valid = 1'b1;
      check_eq($sformatf("bp_ready%0d", i), 64'(bus.req_ready), (i < 3) ? 64'd1 : 64'd0);
      if (i < 3) tick();
    end
    tick_req();
    tick_req();
    check_eq("bp_full_hold", 64'(bus.req_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      wait_resp(c);
      check_eq($sformatf("bp%0d_data", k), bus.resp_data, bp_ex[k]);
      check_eq($sformatf("bp%0d_id", k), 64'(bus.resp_core_id), 64'(bp_id[k]));
      check_eq($sformatf("bp%0d_isw", k), 64'(bus.resp_is_write), 64'(bp_w[k]));
      tick_req();
      tick_req();
      check_eq($sformatf("bp%0d_stall_valid", k), 64'(bus.resp_valid), 64'd1);
      check_eq($sformatf("bp%0d_stall_data", k), bus.resp_data, bp_ex[k]);
      check_eq($sformatf("bp%0d_stall_id", k), 64'(bus.resp_core_id), 64'(bp_id[k]));
      bus.resp_ready = 1'b1;
      tick_req();
      bus.resp_ready = 1'b0;
    end
    check_eq("bp_req3_taken", 64'(bus.req_valid), 64'd0);
    tick();

    // Reset while a write is in BUSY
    txn("wr100", 1'b1, 32'h100, 64'h0123_4567_89AB_CDEF, 8'd20, 64'd0, 1'b0);
    txn("rd100", 1'b0, 32'h100, 64'd0, 8'd21, 64'h0123_4567_89AB_CDEF, 1'b0);
    send(1'b1, 32'h100, 64'hFEED_FACE_FEED_FACE, 8'd22);
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("arst_data", bus.resp_data, 64'd0);
    check_eq("arst_id", 64'(bus.resp_core_id), 64'd0);
    check_eq("arst_ready", 64'(bus.req_ready), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("arst_rel_ready", 64'(bus.req_ready), 64'd1);
    tick();
    txn("rd100_kept", 1'b0, 32'h100, 64'd0, 8'd23, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Latency extremes
    bus_l1.req_is_write = 1'b1; bus_l1.req_addr = 32'h8; bus_l1.req_core_id = 8'd1;
    bus_l15.req_is_write = 1'b1; bus_l15.req_addr = 32'h8; bus_l15.req_core_id = 8'd1;
    bus_l1.req_valid = 1'b1;
    bus_l15.req_valid = 1'b1;
    tick();
    bus_l1.req_valid = 1'b0;
    bus_l15.req_valid = 1'b0;
    c1 = 0;
    c15 = 0;
    for (int k = 1; k < 30; k++) begin
      tick();
      if (bus_l1.resp_valid && c1 == 0) c1 = k;
      if (bus_l15.resp_valid && c15 == 0) c15 = k;
    end
    check_eq("lat1", 64'(c1), 64'd2);
    check_eq("lat15", 64'(c15), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
